// File: rtl/bottleneck_arbiter.sv
// Fair two-master (I fetch / D data) arbiter in front of the bottleneck master port; grant is registered (1 cycle from cyc to bus),
// owner signals pass through combinationally, and a watchdog aborts an owner that strobes without ever getting an ack.
module bottleneck_arbiter #(
  parameter int TO_BITS = 8,
  parameter int TIMEOUT = 200
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] i_adr_i,
  input  logic [1:0]  i_siz_i,
  input  logic        i_cyc_i,
  input  logic        i_stb_i,
  output logic        i_ack_o,
  output logic        i_err_align_o,
  output logic        i_err_timeout_o,
  output logic [63:0] i_dat_o,
  input  logic [63:0] d_adr_i,
  input  logic [63:0] d_dat_i,
  input  logic [1:0]  d_siz_i,
  input  logic        d_cyc_i,
  input  logic        d_stb_i,
  input  logic        d_we_i,
  input  logic        d_signed_i,
  output logic        d_ack_o,
  output logic        d_err_align_o,
  output logic        d_err_timeout_o,
  output logic [63:0] d_dat_o,
  output logic [63:0] b_adr_o,
  output logic [63:0] b_dat_o,
  output logic [1:0]  b_siz_o,
  output logic        b_cyc_o,
  output logic        b_stb_o,
  output logic        b_we_o,
  output logic        b_signed_o,
  input  logic        b_ack_i,
  input  logic        b_err_align_i,
  input  logic [63:0] b_dat_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_I = 2'd1,
    ST_OWN_D = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_last_d, w_last_d_nxt;
  logic               r_abort, w_abort_nxt;
  logic [TO_BITS-1:0] r_wd, w_wd_nxt;

  logic w_own_i, w_own_d, w_own_cyc, w_own_stb, w_stall, w_timeout;

  assign w_own_i   = (r_state == ST_OWN_I);
  assign w_own_d   = (r_state == ST_OWN_D);
  assign w_own_cyc = (w_own_i & i_cyc_i) | (w_own_d & d_cyc_i);
  assign w_own_stb = (w_own_i & i_stb_i) | (w_own_d & d_stb_i);
  assign w_stall   = w_own_stb & ~b_ack_i & ~r_abort;

  // The limit cycle is itself a stalled cycle, so an ack arriving in it suppresses the abort.
  generate
    if (TIMEOUT == 0) begin : g_wd_off
      assign w_timeout = 1'b0;
    end else begin : g_wd_on
      localparam logic [TO_BITS-1:0] LP_LIM = TO_BITS'(TIMEOUT - 1);
      assign w_timeout = w_stall && (r_wd == LP_LIM);
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= ST_IDLE;
      r_last_d <= 1'b0;
      r_abort  <= 1'b0;
      r_wd     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_last_d <= w_last_d_nxt;
      r_abort  <= w_abort_nxt;
      r_wd     <= w_wd_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_last_d_nxt = r_last_d;
    w_abort_nxt  = r_abort;
    w_wd_nxt     = r_wd;

    case (r_state)
      ST_IDLE: begin
        if (d_cyc_i && (!i_cyc_i || !r_last_d)) begin
          w_state_nxt = ST_OWN_D;
        end else if (i_cyc_i) begin
          w_state_nxt = ST_OWN_I;
        end
      end
      ST_OWN_I: begin
        if (!i_cyc_i) w_state_nxt = d_cyc_i ? ST_OWN_D : ST_IDLE;
      end
      ST_OWN_D: begin
        if (!d_cyc_i) w_state_nxt = i_cyc_i ? ST_OWN_I : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_state_nxt == ST_OWN_D && r_state != ST_OWN_D) w_last_d_nxt = 1'b1;
    if (w_state_nxt == ST_OWN_I && r_state != ST_OWN_I) w_last_d_nxt = 1'b0;

    if (w_state_nxt != r_state || b_ack_i || w_timeout) begin
      w_wd_nxt = '0;
    end else if (w_stall) begin
      w_wd_nxt = r_wd + 1'b1;
    end

    // Abort persists until the owner gives up the cycle, then normal release takes over.
    if (!w_own_cyc) begin
      w_abort_nxt = 1'b0;
    end else if (w_timeout) begin
      w_abort_nxt = 1'b1;
    end
  end

  always_comb begin
    b_adr_o         = '0;
    b_dat_o         = '0;
    b_siz_o         = '0;
    b_cyc_o         = 1'b0;
    b_stb_o         = 1'b0;
    b_we_o          = 1'b0;
    b_signed_o      = 1'b0;
    i_ack_o         = 1'b0;
    i_err_align_o   = 1'b0;
    i_err_timeout_o = 1'b0;
    i_dat_o         = '0;
    d_ack_o         = 1'b0;
    d_err_align_o   = 1'b0;
    d_err_timeout_o = 1'b0;
    d_dat_o         = '0;
    grant_o         = {w_own_d, w_own_i};

    if (w_own_i) begin
      b_adr_o         = i_adr_i;
      b_siz_o         = i_siz_i;
      b_cyc_o         = i_cyc_i & ~r_abort;
      b_stb_o         = i_stb_i & ~r_abort;
      i_ack_o         = b_ack_i;
      i_err_align_o   = b_err_align_i;
      i_err_timeout_o = w_timeout;
      i_dat_o         = b_dat_i;
    end else if (w_own_d) begin
      b_adr_o         = d_adr_i;
      b_dat_o         = d_dat_i;
      b_siz_o         = d_siz_i;
      b_cyc_o         = d_cyc_i & ~r_abort;
      b_stb_o         = d_stb_i & ~r_abort;
      b_we_o          = d_we_i;
      b_signed_o      = d_signed_i;
      d_ack_o         = b_ack_i;
      d_err_align_o   = b_err_align_i;
      d_err_timeout_o = w_timeout;
      d_dat_o         = b_dat_i;
    end
  end

endmodule

// File: tb/tb_bottleneck_arbiter.sv
// Bench for bottleneck_arbiter: directed cycle table, hand-written reset/alignment sequences, then random traffic vs a reference model.
module tb_bottleneck_arbiter;
  localparam int TIMEOUT = 4;
  localparam logic [63:0] IA = 64'h1000;
  localparam logic [63:0] DA = 64'h2000;
  localparam logic [63:0] BD = 64'hFFFF_FFFF_FFFF_FF80;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [63:0] i_adr_i, d_adr_i, d_dat_i, b_dat_i;
  logic [1:0]  i_siz_i, d_siz_i;
  logic        i_cyc_i, i_stb_i, d_cyc_i, d_stb_i, d_we_i, d_signed_i, b_ack_i, b_err_align_i;
  logic        i_ack_o, i_err_align_o, i_err_timeout_o, d_ack_o, d_err_align_o, d_err_timeout_o;
  logic [63:0] i_dat_o, d_dat_o, b_adr_o, b_dat_o;
  logic [1:0]  b_siz_o, grant_o;
  logic        b_cyc_o, b_stb_o, b_we_o, b_signed_o;

  always #5 clk_i = ~clk_i;

  bottleneck_arbiter #(.TO_BITS(8), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .i_adr_i(i_adr_i), .i_siz_i(i_siz_i), .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i),
    .i_ack_o(i_ack_o), .i_err_align_o(i_err_align_o), .i_err_timeout_o(i_err_timeout_o), .i_dat_o(i_dat_o),
    .d_adr_i(d_adr_i), .d_dat_i(d_dat_i), .d_siz_i(d_siz_i), .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i),
    .d_we_i(d_we_i), .d_signed_i(d_signed_i),
    .d_ack_o(d_ack_o), .d_err_align_o(d_err_align_o), .d_err_timeout_o(d_err_timeout_o), .d_dat_o(d_dat_o),
    .b_adr_o(b_adr_o), .b_dat_o(b_dat_o), .b_siz_o(b_siz_o), .b_cyc_o(b_cyc_o), .b_stb_o(b_stb_o),
    .b_we_o(b_we_o), .b_signed_o(b_signed_o),
    .b_ack_i(b_ack_i), .b_err_align_i(b_err_align_i), .b_dat_i(b_dat_i),
    .grant_o(grant_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // {i_cyc, i_stb, d_cyc, d_stb, b_ack, b_err_align}
  task automatic drive(input logic [5:0] v);
    {i_cyc_i, i_stb_i, d_cyc_i, d_stb_i, b_ack_i, b_err_align_i} = v;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic [5:0]  in;
    logic [1:0]  grant;
    logic [7:0]  ctl;    // {b_cyc, b_stb, i_ack, d_ack, i_to, d_to, i_err, d_err}
    logic [63:0] badr;
  } vec_t;

  function automatic vec_t v(input logic [5:0] in, input logic [1:0] g, input logic [7:0] c, input logic [63:0] a);
    vec_t r;
    r.in = in; r.grant = g; r.ctl = c; r.badr = a;
    return r;
  endfunction

  vec_t tbl[25];

  // Reference model: who owns the bus, fairness memory, abort flag, consecutive stalled cycles.
  int   m_owner;   // 0 none, 1 I, 2 D
  bit   m_last_d, m_abort, m_to;
  int   m_stalls;

  task automatic model_check();
    logic own_i, own_d, o_cyc, o_stb;
    own_i = (m_owner == 1);
    own_d = (m_owner == 2);
    o_cyc = own_i ? i_cyc_i : (own_d ? d_cyc_i : 1'b0);
    o_stb = own_i ? i_stb_i : (own_d ? d_stb_i : 1'b0);
    m_to  = (m_owner != 0) && o_stb && !b_ack_i && !m_abort && (m_stalls + 1 == TIMEOUT);
    chk("rnd grant", 64'({own_d, own_i}), 64'(grant_o));
    chk("rnd b_adr", b_adr_o, own_i ? i_adr_i : (own_d ? d_adr_i : 64'h0));
    chk("rnd b_dat", b_dat_o, own_d ? d_dat_i : 64'h0);
    chk("rnd b_ctl", 64'({b_siz_o, b_cyc_o, b_stb_o, b_we_o, b_signed_o}),
        64'({own_i ? i_siz_i : (own_d ? d_siz_i : 2'b00), o_cyc & ~m_abort, o_stb & ~m_abort,
             own_d & d_we_i, own_d & d_signed_i}));
    chk("rnd i_flags", 64'({i_ack_o, i_err_align_o, i_err_timeout_o}),
        64'({own_i & b_ack_i, own_i & b_err_align_i, own_i & m_to}));
    chk("rnd d_flags", 64'({d_ack_o, d_err_align_o, d_err_timeout_o}),
        64'({own_d & b_ack_i, own_d & b_err_align_i, own_d & m_to}));
    chk("rnd i_dat", i_dat_o, own_i ? b_dat_i : 64'h0);
    chk("rnd d_dat", d_dat_o, own_d ? b_dat_i : 64'h0);
  endtask

  task automatic model_update();
    int  nxt;
    bit  o_cyc, o_stb;
    o_cyc = (m_owner == 1) ? i_cyc_i : ((m_owner == 2) ? d_cyc_i : 1'b0);
    o_stb = (m_owner == 1) ? i_stb_i : ((m_owner == 2) ? d_stb_i : 1'b0);
    if (m_owner == 0) begin
      if (i_cyc_i && d_cyc_i) nxt = m_last_d ? 1 : 2;
      else if (d_cyc_i)       nxt = 2;
      else if (i_cyc_i)       nxt = 1;
      else                    nxt = 0;
    end else if (!o_cyc) begin
      nxt = (m_owner == 1) ? (d_cyc_i ? 2 : 0) : (i_cyc_i ? 1 : 0);
    end else begin
      nxt = m_owner;
    end
    if (nxt != m_owner && nxt != 0) m_last_d = (nxt == 2);
    if (nxt != m_owner || b_ack_i || m_to) m_stalls = 0;
    else if (o_stb && !m_abort)            m_stalls = m_stalls + 1;
    if (!o_cyc)    m_abort = 0;
    else if (m_to) m_abort = 1;
    m_owner = nxt;
  endtask

  initial begin
    tbl[0]  = v(6'b110000, 2'b00, 8'b00000000, 64'h0);
    tbl[1]  = v(6'b110000, 2'b01, 8'b11000000, IA);
    tbl[2]  = v(6'b110000, 2'b01, 8'b11000000, IA);
    tbl[3]  = v(6'b110000, 2'b01, 8'b11000000, IA);
    tbl[4]  = v(6'b110010, 2'b01, 8'b11100000, IA);   // ack on the limit cycle wins
    tbl[5]  = v(6'b000000, 2'b01, 8'b00000000, IA);
    tbl[6]  = v(6'b000000, 2'b00, 8'b00000000, 64'h0);
    tbl[7]  = v(6'b101000, 2'b00, 8'b00000000, 64'h0);
    tbl[8]  = v(6'b101000, 2'b10, 8'b10000000, DA);   // tie, last owner I -> D
    tbl[9]  = v(6'b101110, 2'b10, 8'b11010000, DA);
    tbl[10] = v(6'b100000, 2'b10, 8'b00000000, DA);
    tbl[11] = v(6'b110000, 2'b01, 8'b11000000, IA);   // direct handover, no idle gap
    tbl[12] = v(6'b000000, 2'b01, 8'b00000000, IA);
    tbl[13] = v(6'b101000, 2'b00, 8'b00000000, 64'h0);
    tbl[14] = v(6'b101100, 2'b10, 8'b11000000, DA);
    tbl[15] = v(6'b101100, 2'b10, 8'b11000000, DA);
    tbl[16] = v(6'b101100, 2'b10, 8'b11000000, DA);
    tbl[17] = v(6'b101100, 2'b10, 8'b11000100, DA);   // fourth stalled cycle -> timeout
    tbl[18] = v(6'b101100, 2'b10, 8'b00000000, DA);
    tbl[19] = v(6'b101100, 2'b10, 8'b00000000, DA);
    tbl[20] = v(6'b100000, 2'b10, 8'b00000000, DA);
    tbl[21] = v(6'b110000, 2'b01, 8'b11000000, IA);
    tbl[22] = v(6'b110001, 2'b01, 8'b11000010, IA);
    tbl[23] = v(6'b000000, 2'b01, 8'b00000000, IA);
    tbl[24] = v(6'b000000, 2'b00, 8'b00000000, 64'h0);

    i_adr_i = IA; d_adr_i = DA; d_dat_i = 64'hD0D0; b_dat_i = BD;
    i_siz_i = 2'b11; d_siz_i = 2'b00; d_we_i = 1'b0; d_signed_i = 1'b1;

    reset_i = 1'b0;
    drive(6'b111111);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset grant", 64'(grant_o), 64'h0);
    chk("reset b_ctl", 64'({b_cyc_o, b_stb_o, b_we_o, b_signed_o}), 64'h0);
    chk("reset b_adr", b_adr_o, 64'h0);
    chk("reset flags", 64'({i_ack_o, i_err_align_o, i_err_timeout_o, d_ack_o, d_err_align_o, d_err_timeout_o}), 64'h0);
    chk("reset d_dat", d_dat_o, 64'h0);
    drive(6'b000000);
    reset_i = 1'b1;

    for (int r = 0; r < 25; r++) begin
      tick();
      drive(tbl[r].in);
      @(negedge clk_i);
      chk($sformatf("tbl[%0d] grant", r), 64'(grant_o), 64'(tbl[r].grant));
      chk($sformatf("tbl[%0d] ctl", r),
          64'({b_cyc_o, b_stb_o, i_ack_o, d_ack_o, i_err_timeout_o, d_err_timeout_o, i_err_align_o, d_err_align_o}),
          64'(tbl[r].ctl));
      chk($sformatf("tbl[%0d] b_adr", r), b_adr_o, tbl[r].badr);
      chk($sformatf("tbl[%0d] d_dat", r), d_dat_o, (tbl[r].grant == 2'b10) ? BD : 64'h0);
      chk($sformatf("tbl[%0d] i_dat", r), i_dat_o, (tbl[r].grant == 2'b01) ? BD : 64'h0);
      chk($sformatf("tbl[%0d] b_signed", r), 64'(b_signed_o), (tbl[r].grant == 2'b10) ? 64'h1 : 64'h0);
    end

    // Misaligned D access: error goes only to D and does not release the grant.
    tick(); drive(6'b001100); @(negedge clk_i);
    tick(); drive(6'b101101); @(negedge clk_i);
    chk("align d_err", 64'(d_err_align_o), 64'h1);
    chk("align i_err", 64'(i_err_align_o), 64'h0);
    chk("align grant", 64'(grant_o), 64'h2);
    tick(); drive(6'b101100); @(negedge clk_i);
    chk("align held", 64'(grant_o), 64'h2);
    tick(); drive(6'b100000); @(negedge clk_i);
    chk("align drop", 64'(grant_o), 64'h2);
    tick(); @(negedge clk_i);
    chk("align to I", 64'(grant_o), 64'h1);
    tick(); drive(6'b000000); @(negedge clk_i);
    tick(); @(negedge clk_i);
    chk("align idle", 64'(grant_o), 64'h0);

    // Asynchronous reset in the middle of a D cycle, then a tie must again go to D.
    tick(); drive(6'b001100); @(negedge clk_i);
    tick(); @(negedge clk_i);
    chk("pre-reset b_cyc", 64'(b_cyc_o), 64'h1);
    #1 reset_i = 1'b0;
    #1;
    chk("async reset bus", 64'({b_cyc_o, b_stb_o, grant_o}), 64'h0);
    drive(6'b101000);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    tick(); @(negedge clk_i);
    chk("tie after reset", 64'(grant_o), 64'h2);

    reset_i = 1'b0;
    drive(6'b000000);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    m_owner = 0; m_last_d = 0; m_abort = 0; m_stalls = 0; m_to = 0;

    for (int c = 0; c < 2000; c++) begin
      tick();
      if ($urandom_range(5) == 0) i_cyc_i = ~i_cyc_i;
      if ($urandom_range(5) == 0) d_cyc_i = ~d_cyc_i;
      i_stb_i       = i_cyc_i & ($urandom_range(3) != 0);
      d_stb_i       = d_cyc_i & ($urandom_range(3) != 0);
      b_ack_i       = ($urandom_range(3) == 0);
      b_err_align_i = ($urandom_range(15) == 0);
      i_adr_i       = {$urandom, $urandom};
      d_adr_i       = {$urandom, $urandom};
      d_dat_i       = {$urandom, $urandom};
      b_dat_i       = {$urandom, $urandom};
      i_siz_i       = 2'($urandom_range(3));
      d_siz_i       = 2'($urandom_range(3));
      d_we_i        = 1'($urandom_range(1));
      d_signed_i    = 1'($urandom_range(1));
      @(negedge clk_i);
      model_check();
      model_update();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
